// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with flop-array storage,
// per-set round-robin replacement and single-burst AXI4 line refill.
module icache_nway #(
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_SETS       = 64,
  parameter int LINE_BYTES     = 64,
  parameter int NUM_WAYS       = 4,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ID         = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     req_pc,
  input  logic                      req_rd,
  output logic                      req_accept,
  output logic                      req_valid,
  output logic [LINE_BYTES*8-1:0]   req_data,
  output logic                      req_error,
  input  logic                      inv_req,
  output logic                      inv_done,
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  output logic [AXI_ID_WIDTH-1:0]   axi_arid,
  output logic [ADDR_WIDTH-1:0]     axi_araddr,
  output logic [7:0]                axi_arlen,
  output logic [2:0]                axi_arsize,
  output logic [1:0]                axi_arburst,
  output logic                      axi_arlock,
  output logic [3:0]                axi_arcache,
  output logic [2:0]                axi_arprot,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  input  logic [AXI_ID_WIDTH-1:0]   axi_rid,
  input  logic [1:0]                axi_rresp,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic                      axi_rlast,
  output logic [1:0]                dbg_state
);

  localparam int LINE_BITS = LINE_BYTES * 8;
  localparam int OFF_W     = $clog2(LINE_BYTES);
  localparam int IDX_W     = $clog2(NUM_SETS);
  localparam int TAG_W     = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int WAY_W     = $clog2(NUM_WAYS);
  localparam int BEATS     = LINE_BITS / AXI_DATA_WIDTH;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // Handshakes: AR and R transfers complete on a clock edge where valid && ready.
  // The response side has no back-pressure: req_valid is a one-cycle strobe.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MISS_AR = 2'd1,
    S_MISS_R  = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic [NUM_WAYS-1:0]  r_valid [NUM_SETS];
  logic [TAG_W-1:0]     r_tag   [NUM_SETS][NUM_WAYS];
  logic [LINE_BITS-1:0] r_data  [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]     r_rr    [NUM_SETS];

  logic                 r_req_valid, r_req_error, r_inv_done, r_inv_pending;
  logic [LINE_BITS-1:0] r_req_data, r_line;
  logic                 r_arvalid, r_rready, r_err;
  logic [BEAT_W-1:0]    r_beat;
  logic [TAG_W-1:0]     r_miss_tag;
  logic [IDX_W-1:0]     r_miss_idx;
  logic [WAY_W-1:0]     r_victim;

  logic [TAG_W-1:0]     w_req_tag;
  logic [IDX_W-1:0]     w_req_idx;
  logic                 w_accept, w_fire_req, w_do_inv;
  logic                 w_hit;
  logic [LINE_BITS-1:0] w_hit_line, w_line_asm;
  logic [WAY_W-1:0]     w_victim;
  logic                 w_beat_fire, w_final, w_err_next;
  logic                 w_unused;

  assign w_req_tag   = req_pc[ADDR_WIDTH-1 -: TAG_W];
  assign w_req_idx   = req_pc[OFF_W +: IDX_W];
  assign w_accept    = (r_state == S_IDLE) && !inv_req && !r_inv_pending;
  assign w_fire_req  = req_rd && w_accept;
  assign w_do_inv    = (r_state == S_IDLE) && (inv_req || r_inv_pending);
  assign w_beat_fire = (r_state == S_MISS_R) && axi_rvalid && r_rready;
  assign w_final     = w_beat_fire && (r_beat == LAST_BEAT);
  // Burst length is fixed; an early or missing rlast only taints the response.
  assign w_err_next  = r_err || (axi_rresp != 2'b00) || (axi_rlast != (r_beat == LAST_BEAT));
  assign w_unused    = ^{axi_rid, req_pc[OFF_W-1:0]};

  always_comb begin
    w_hit      = 1'b0;
    w_hit_line = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w_req_idx][WAY_W'(w)] && (r_tag[w_req_idx][WAY_W'(w)] == w_req_tag)) begin
        w_hit      = 1'b1;
        w_hit_line = w_hit_line | r_data[w_req_idx][WAY_W'(w)];
      end
    end
  end

  // Lowest-numbered invalid way wins; a full set falls back to the rr pointer.
  always_comb begin
    w_victim = r_rr[w_req_idx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_req_idx][WAY_W'(w)]) w_victim = WAY_W'(w);
    end
  end

  always_comb begin
    w_line_asm = r_line;
    if (w_beat_fire) w_line_asm[int'(r_beat) * AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = axi_rdata;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_fire_req && !w_hit) w_state_next = S_MISS_AR;
      S_MISS_AR: if (axi_arready) w_state_next = S_MISS_R;
      S_MISS_R:  if (w_final) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[IDX_W'(s)] <= '0;
        r_rr[IDX_W'(s)]    <= '0;
      end
      r_req_valid   <= 1'b0;
      r_req_error   <= 1'b0;
      r_req_data    <= '0;
      r_inv_done    <= 1'b0;
      r_inv_pending <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_err         <= 1'b0;
      r_beat        <= '0;
      r_line        <= '0;
      r_miss_tag    <= '0;
      r_miss_idx    <= '0;
      r_victim      <= '0;
    end else begin
      r_req_valid <= 1'b0;
      r_inv_done  <= 1'b0;
      if (inv_req && (r_state != S_IDLE)) r_inv_pending <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_do_inv) begin
            for (int s = 0; s < NUM_SETS; s++) r_valid[IDX_W'(s)] <= '0;
            r_inv_done    <= 1'b1;
            r_inv_pending <= 1'b0;
          end else if (w_fire_req) begin
            if (w_hit) begin
              r_req_valid <= 1'b1;
              r_req_data  <= w_hit_line;
              r_req_error <= 1'b0;
            end else begin
              r_miss_tag <= w_req_tag;
              r_miss_idx <= w_req_idx;
              r_victim   <= w_victim;
              r_err      <= 1'b0;
              r_arvalid  <= 1'b1;
            end
          end
        end
        S_MISS_AR: begin
          if (axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_beat    <= '0;
          end
        end
        S_MISS_R: begin
          if (w_beat_fire) begin
            r_line <= w_line_asm;
            r_err  <= w_err_next;
            r_beat <= r_beat + BEAT_W'(1);
            if (w_final) begin
              r_rready    <= 1'b0;
              r_req_valid <= 1'b1;
              r_req_data  <= w_line_asm;
              r_req_error <= w_err_next;
              if (!w_err_next) begin
                r_valid[r_miss_idx][r_victim] <= 1'b1;
                if (r_victim == r_rr[r_miss_idx]) r_rr[r_miss_idx] <= r_rr[r_miss_idx] + WAY_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and line payload carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (w_final && !w_err_next) begin
      r_tag[r_miss_idx][r_victim]  <= r_miss_tag;
      r_data[r_miss_idx][r_victim] <= w_line_asm;
    end
  end

  assign req_accept  = w_accept;
  assign req_valid   = r_req_valid;
  assign req_data    = r_req_data;
  assign req_error   = r_req_error;
  assign inv_done    = r_inv_done;
  assign axi_arvalid = r_arvalid;
  assign axi_rready  = r_rready;
  assign axi_arid    = AXI_ID_WIDTH'(AXI_ID);
  assign axi_araddr  = {r_miss_tag, r_miss_idx, {OFF_W{1'b0}}};
  assign axi_arlen   = 8'(BEATS - 1);
  assign axi_arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign axi_arburst = 2'b01;
  assign axi_arlock  = 1'b0;
  assign axi_arcache = 4'b0011;
  assign axi_arprot  = 3'b100;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_icache_nway.sv
// Randomized bench for icache_nway: an AXI read-slave driver plus a set/way
// reference model of the cache contents and replacement order.
module tb_icache_nway;

  localparam int AW    = 32;
  localparam int NS    = 64;
  localparam int LB    = 64;
  localparam int NW    = 4;
  localparam int IDW   = 4;
  localparam int DW    = 128;
  localparam int LBITS = LB * 8;
  localparam int BEATS = LBITS / DW;

  logic             clk, rst;
  logic [AW-1:0]    req_pc;
  logic             req_rd, req_accept, req_valid, req_error;
  logic [LBITS-1:0] req_data;
  logic             inv_req, inv_done;
  logic             axi_arvalid, axi_arready, axi_arlock;
  logic [IDW-1:0]   axi_arid, axi_rid;
  logic [AW-1:0]    axi_araddr;
  logic [7:0]       axi_arlen;
  logic [2:0]       axi_arsize, axi_arprot;
  logic [1:0]       axi_arburst, axi_rresp;
  logic [3:0]       axi_arcache;
  logic             axi_rvalid, axi_rready, axi_rlast;
  logic [DW-1:0]    axi_rdata;
  logic [1:0]       dbg_state;

  icache_nway #(
    .ADDR_WIDTH(AW), .NUM_SETS(NS), .LINE_BYTES(LB), .NUM_WAYS(NW),
    .AXI_ID_WIDTH(IDW), .AXI_DATA_WIDTH(DW), .AXI_ID(0)
  ) dut (
    .clk(clk), .rst(rst), .req_pc(req_pc), .req_rd(req_rd), .req_accept(req_accept),
    .req_valid(req_valid), .req_data(req_data), .req_error(req_error),
    .inv_req(inv_req), .inv_done(inv_done),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
    .axi_arprot(axi_arprot), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_rid(axi_rid), .axi_rresp(axi_rresp), .axi_rdata(axi_rdata),
    .axi_rlast(axi_rlast), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [LBITS-1:0] obs, input logic [LBITS-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: contents per set/way and the rr pointer per set
  logic             m_valid [NS][NW];
  int unsigned      m_tag   [NS][NW];
  logic [LBITS-1:0] m_data  [NS][NW];
  int               m_rr    [NS];

  function automatic int m_set(input logic [AW-1:0] pc);
    return int'((pc / LB) % NS);
  endfunction

  function automatic int unsigned m_tagof(input logic [AW-1:0] pc);
    return pc / (LB * NS);
  endfunction

  function automatic int m_lookup(input logic [AW-1:0] pc);
    for (int w = 0; w < NW; w++)
      if (m_valid[m_set(pc)][w] && m_tag[m_set(pc)][w] == m_tagof(pc)) return w;
    return -1;
  endfunction

  function automatic void m_fill(input logic [AW-1:0] pc, input logic [LBITS-1:0] line);
    int s, v;
    s = m_set(pc);
    v = m_rr[s];
    for (int w = NW - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = m_tagof(pc);
    m_data[s][v]  = line;
    if (v == m_rr[s]) m_rr[s] = (m_rr[s] + 1) % NW;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
  endfunction

  // driver tasks
  task automatic fetch(input logic [AW-1:0] pc, input int err_beat, input int last_beat, input int inv_beat);
    int way;
    logic exp_err;
    logic [LBITS-1:0] line;
    logic [DW-1:0] beat;
    @(negedge clk);
    check_eq("accept", req_accept, 1);
    way = m_lookup(pc);
    req_pc = pc;
    req_rd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_rd = 1'b0;
    if (way >= 0) begin
      check_eq("hit_valid", req_valid, 1);
      check_eq("hit_data", req_data, m_data[m_set(pc)][way]);
      check_eq("hit_error", req_error, 0);
      check_eq("hit_no_ar", axi_arvalid, 0);
      @(negedge clk);
      check_eq("hit_pulse", req_valid, 0);
      return;
    end
    check_eq("miss_no_resp", req_valid, 0);
    check_eq("arvalid", axi_arvalid, 1);
    if (!axi_arvalid) return;
    check_eq("araddr", axi_araddr, pc & ~(AW'(LB - 1)));
    check_eq("arlen", axi_arlen, BEATS - 1);
    check_eq("arsize", axi_arsize, 4);
    check_eq("arburst", axi_arburst, 1);
    check_eq("arid", axi_arid, 0);
    check_eq("arprot_cache_lock", {axi_arprot, axi_arcache, axi_arlock}, {3'b100, 4'b0011, 1'b0});
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check_eq("ar_hold", axi_arvalid, 1);
    axi_arready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi_arready = 1'b0;
    check_eq("ar_drop", axi_arvalid, 0);
    check_eq("rready_up", axi_rready, 1);
    line = '0;
    for (int b = 0; b < BEATS; b++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      beat       = {$urandom, $urandom, $urandom, $urandom};
      axi_rvalid = 1'b1;
      axi_rdata  = beat;
      axi_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
      axi_rlast  = (b == last_beat);
      axi_rid    = IDW'($urandom_range(0, 15));
      inv_req    = (b == inv_beat);
      @(posedge clk);
      @(negedge clk);
      axi_rvalid = 1'b0;
      axi_rlast  = 1'b0;
      inv_req    = 1'b0;
      line[b*DW +: DW] = beat;
    end
    exp_err = (err_beat >= 0 && err_beat < BEATS) || (last_beat != BEATS - 1);
    check_eq("resp_valid", req_valid, 1);
    check_eq("resp_data", req_data, line);
    check_eq("resp_error", req_error, exp_err);
    check_eq("rready_down", axi_rready, 0);
    if (!exp_err) m_fill(pc, line);
    if (inv_beat >= 0) begin
      check_eq("pending_blocks", req_accept, 0);
      @(negedge clk);
      check_eq("inv_done_after_fill", inv_done, 1);
      check_eq("inv_resp_pulse", req_valid, 0);
      m_clear();
    end else begin
      @(negedge clk);
      check_eq("resp_pulse", req_valid, 0);
    end
  endtask

  task automatic fetch_pair(input logic [AW-1:0] pc1, input logic [AW-1:0] pc2);
    logic [LBITS-1:0] e1, e2;
    e1 = (m_lookup(pc1) >= 0) ? m_data[m_set(pc1)][m_lookup(pc1)] : '0;
    e2 = (m_lookup(pc2) >= 0) ? m_data[m_set(pc2)][m_lookup(pc2)] : '0;
    @(negedge clk);
    req_pc = pc1;
    req_rd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("b2b_valid1", req_valid, 1);
    check_eq("b2b_data1", req_data, e1);
    check_eq("b2b_accept2", req_accept, 1);
    req_pc = pc2;
    @(posedge clk);
    @(negedge clk);
    req_rd = 1'b0;
    check_eq("b2b_valid2", req_valid, 1);
    check_eq("b2b_data2", req_data, e2);
    check_eq("b2b_no_ar", axi_arvalid, 0);
  endtask

  task automatic invalidate(input logic with_req);
    @(negedge clk);
    inv_req = 1'b1;
    req_rd  = with_req;
    req_pc  = 32'h0000_1040;
    #1;
    check_eq("inv_accept_low", req_accept, 0);
    @(posedge clk);
    @(negedge clk);
    inv_req = 1'b0;
    req_rd  = 1'b0;
    check_eq("inv_done", inv_done, 1);
    check_eq("inv_no_resp", req_valid, 0);
    check_eq("inv_no_ar", axi_arvalid, 0);
    m_clear();
    @(negedge clk);
    check_eq("inv_done_pulse", inv_done, 0);
  endtask

  initial begin
    logic [AW-1:0] pc;
    int eb, lb_;
    rst = 1'b0;
    req_pc = '0; req_rd = 1'b0; inv_req = 1'b0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rid = '0;
    axi_rresp = 2'b00; axi_rdata = '0; axi_rlast = 1'b0;
    m_clear();
    for (int s = 0; s < NS; s++) m_rr[s] = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_valid", req_valid, 0);
    check_eq("rst_req_data", req_data, 0);
    check_eq("rst_req_error", req_error, 0);
    check_eq("rst_inv_done", inv_done, 0);
    check_eq("rst_arvalid", axi_arvalid, 0);
    check_eq("rst_rready", axi_rready, 0);
    check_eq("rst_accept", req_accept, 1);
    rst = 1'b1;

    fetch(32'h0000_1040, -1, 3, -1);
    fetch_pair(32'h0000_1040, 32'h0000_1050);
    for (int t = 2; t <= 5; t++) fetch(AW'(t * 32'h1000 + 32'h40), -1, 3, -1);
    fetch(32'h0000_2040, -1, 3, -1);
    fetch(32'h0000_1040, -1, 3, -1);
    fetch(32'h0000_7040, 2, 3, -1);
    fetch(32'h0000_7040, -1, 3, -1);
    fetch(32'h0000_8080, -1, 1, -1);
    fetch(32'h0000_9080, -1, 3, 1);
    fetch(32'h0000_9080, -1, 3, -1);
    invalidate(1'b1);

    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 99) < 5) begin
        invalidate(1'b0);
      end else begin
        pc = (AW'($urandom_range(1, 6)) << 12) | (AW'($urandom_range(0, 2)) << 6)
           | AW'($urandom_range(0, 15) * 4);
        eb  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
        lb_ = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : 3;
        fetch(pc, eb, lb_, -1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/icache_nway.md
Name: icache_nway

Overview:
- N-way set-associative, read-only instruction cache with a parametrised line size, set count and way count.
- Sits between the fetch stage (req_pc / req_rd) and the AXI4 memory read channel.
- Refills a whole line by a single multi-beat INCR burst.
- Replacement is per-set round-robin, with invalid ways preferred.
- Supports a full-cache invalidate, returns the fetched line, and flags bus errors.

Parameters:
- ADDR_WIDTH, 32, fetch/AXI address width.
- NUM_SETS, 64, number of sets; power of 2.
- LINE_BYTES, 64, line size in bytes; power of 2.
- NUM_WAYS, 4, associativity; power of 2, >=2.
- AXI_ID_WIDTH, 4, ARID/RID width.
- AXI_DATA_WIDTH, 128, R data width; LINE_BYTES*8 must be a multiple of it.
- AXI_ID, 0, constant ARID value.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- req_pc  input  ADDR_WIDTH  fetch address; line offset ignored
- req_rd  input  1  fetch request
- req_accept  output  1  request taken when req_rd && req_accept
- req_valid  output  1  one-cycle response strobe
- req_data  output  LINE_BYTES*8  returned line
- req_error  output  1  response qualifier: refill got non-OKAY
- inv_req  input  1  invalidate-all pulse
- inv_done  output  1  one-cycle pulse when invalidate applied
- axi_arvalid, axi_arready  output/input  1  AR handshake
- axi_arid  output  AXI_ID_WIDTH  = AXI_ID
- axi_araddr  output  ADDR_WIDTH  line-aligned miss address
- axi_arlen  output  8  BEATS-1
- axi_arsize  output  3  log2(AXI_DATA_WIDTH/8)
- axi_arburst  output  2  2'b01 (INCR)
- axi_arlock  output  1  0
- axi_arcache  output  4  4'b0011
- axi_arprot  output  3  3'b100 (instruction)
- axi_rvalid, axi_rready  input/output  1  R handshake
- axi_rid  input  AXI_ID_WIDTH  ignored (single outstanding burst)
- axi_rresp  input  2  beat response
- axi_rdata  input  AXI_DATA_WIDTH  beat data
- axi_rlast  input  1  last beat

Behaviour:
- Address split: offset = log2(LINE_BYTES) LSBs; index = log2(NUM_SETS); tag = remainder.
- BEATS = LINE_BYTES*8/AXI_DATA_WIDTH.
- Storage is flop arrays: tag, valid and line data per set/way, plus a log2(NUM_WAYS)-bit round-robin pointer per set.
- Reset (rst low, async) clears:
  - all valid bits and rr pointers;
  - state=IDLE, beat counter 0;
  - req_valid, req_error, inv_done, axi_arvalid, axi_rready, inv_pending to 0;
  - req_data to 0.
- States: IDLE, MISS_AR, MISS_R.
- req_accept = (state==IDLE) && !inv_req && !inv_pending (combinational).
- IDLE, accepted request: all ways of the indexed set are compared that cycle.
  - Hit (valid && tag match, at most one way): next edge sets req_valid=1, req_data=hit line, req_error=0. Stay IDLE.
  - Hit latency is 1 cycle; back-to-back hits are accepted every cycle.
  - Miss: latch tag/index. Victim = lowest-numbered invalid way, else rr[index]. Go MISS_AR. req_valid=0.
- req_valid is a single-cycle pulse. Consumer must always be ready; there is no stall.
- MISS_AR:
  - axi_arvalid=1, araddr={tag,index,0} stable until handshake.
  - On arready: arvalid=0, rready=1, beat counter=0, go MISS_R.
- MISS_R:
  - Each rvalid beat is stored into line buffer slot [beat]; beat 0 is the lowest bits.
  - Any non-OKAY rresp sets a sticky error flag.
  - Final beat is beat==BEATS-1; rlast is not used to terminate.
  - If rlast differs from (beat==BEATS-1) on any beat, the sticky error flag is set.
  - On final beat: rready=0, go IDLE. Next edge sets req_valid=1, req_data=assembled line, req_error=sticky.
  - Fill with no error: write tag/data to victim way, set valid. If victim==rr[index], rr[index] increments, wrapping NUM_WAYS-1 -> 0.
  - Fill with error: no array write, rr unchanged.
- Invalidate:
  - inv_req in IDLE: next edge clears all valid bits and pulses inv_done.
  - inv_req in a miss state: sets inv_pending. The fill completes and its response is delivered normally, then the clear and inv_done happen on the first IDLE cycle, before any new accept.
  - inv_req together with req_rd in IDLE: invalidate wins; the request is not accepted (req_accept=0).
- A refill to the same set as a prior fill overwrites only the victim way; other ways keep their contents.
- Reset mid-burst: the AXI interface is abandoned. The system resets the interconnect together with the cache.

Test Plan:
- Cold miss at 0x0000_1040 -> arvalid, araddr=0x0000_1040, arlen=3, arsize=4, arburst=1. Four OKAY beats D0..D3 -> req_valid one cycle, req_data={D3,D2,D1,D0}, req_error=0.
- Same PC again, back-to-back with 0x0000_1050 (same line) -> req_valid on the cycle after each accept, identical data, no AR.
- Five distinct tags mapping to set 1 (stride NUM_SETS*LINE_BYTES=0x1000) -> ways 0..3 filled, then fifth evicts way 0. Refetch of the first tag misses; refetch of the second tag hits.
- Refill with rresp=2'b10 on beat 2 -> req_error=1. Immediate refetch of the same PC misses again (line not allocated).
- rlast asserted on beat 1 -> burst still consumes 4 beats, req_error=1.
- inv_req during MISS_R -> fill response delivered, then inv_done pulses. Refetch misses. inv_req with req_rd in IDLE -> req_accept=0 that cycle.
